// File: rtl/nibble_frame_loader_pkg.sv
// Shared types and constants for the serial-to-nibble frame loader.
// Frame layout is address (MSB first) followed by one data nibble (MSB first).
package nibble_frame_loader_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_LOAD     = 2'd2,
    ST_WAIT_END = 2'd3
  } loader_state_e;

  function automatic int frame_bits(input int addr_w);
    return addr_w + NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_frame_loader_idle_timer.sv
// Counts consecutive idle cycles inside a frame. expire is high during the
// enabled cycle that completes TIMEOUT idle cycles in a row.
module frame_idle_timer #(
  parameter int TIMEOUT = 255,
  parameter int TMR_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST_IDLE = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SAT_VAL   = TMR_W'(TIMEOUT);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != SAT_VAL)) begin
      count_q <= count_q + TMR_W'(1);
    end
  end

  assign expire = enable && (count_q == LAST_IDLE);

endmodule

// File: rtl/nibble_frame_loader.sv
// Assembles a serial address+nibble frame and drives the shared nibble bus
// with a one-hot load strobe; flags short, overlong, stalled and bad-address frames.
module nibble_frame_loader
  import nibble_frame_loader_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter int TIMEOUT  = 255,
  parameter int TMR_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                SDI,
  input  logic                SVALID,
  input  logic                SFRAME,
  output logic [NIBBLE_W-1:0] DATA,
  output logic [NUM_REGS-1:0] LOAD,
  output logic                BUSY,
  output logic                ERR,
  output loader_state_e       dbg_state
);

  localparam int FRAME_BITS = frame_bits(ADDR_W);
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  // Bit strobe: a bit is taken whenever SVALID and SFRAME are both high in
  // an accepting state. There is no backpressure; the sender never waits.

  loader_state_e state_q, state_d;
  logic [FRAME_BITS-2:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sframe_q;
  logic [NUM_REGS-1:0]   load_q, load_d;
  logic [NIBBLE_W-1:0]   data_q, data_d;
  logic                  err_q, err_d;

  // The final bit goes straight from SDI into the decode, so the
  // register only ever holds the first FRAME_BITS-1 bits.
  logic [FRAME_BITS-1:0] shift_in;
  logic [ADDR_W-1:0]     frame_addr;
  logic [NIBBLE_W-1:0]   frame_nib;
  logic                  addr_ok;
  logic [NUM_REGS-1:0]   addr_onehot;
  logic                  frame_start;
  logic                  tmr_clear;
  logic                  tmr_enable;
  logic                  tmr_expire;

  assign shift_in    = {shift_q, SDI};
  assign frame_addr  = shift_in[FRAME_BITS-1 -: ADDR_W];
  assign frame_nib   = shift_in[NIBBLE_W-1:0];
  assign addr_ok     = int'(frame_addr) < NUM_REGS;
  assign frame_start = SFRAME && !sframe_q;

  always_comb begin
    addr_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (frame_addr == ADDR_W'(i)) addr_onehot[i] = 1'b1;
    end
  end

  assign tmr_enable = (state_q == ST_SHIFT) && SFRAME && !SVALID;
  assign tmr_clear  = (state_q != ST_SHIFT) || SVALID;

  frame_idle_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    load_d  = '0;
    data_d  = data_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        shift_d = '0;
        cnt_d   = '0;
        if (frame_start) begin
          state_d = ST_SHIFT;
          if (SVALID) begin
            shift_d[0] = SDI;
            cnt_d      = CNT_W'(1);
          end
        end
      end
      ST_SHIFT: begin
        if (!SFRAME) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (SVALID) begin
          shift_d = shift_in[FRAME_BITS-2:0];
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = ST_LOAD;
            if (addr_ok) begin
              load_d = addr_onehot;
              data_d = frame_nib;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (tmr_expire) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT_END;
        end
      end
      ST_LOAD: begin
        // A bit landing in the load cycle already makes the frame overlong.
        err_d   = SVALID && SFRAME;
        state_d = SFRAME ? ST_WAIT_END : ST_IDLE;
      end
      ST_WAIT_END: begin
        if (!SFRAME) begin
          state_d = ST_IDLE;
        end else if (SVALID) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      sframe_q <= 1'b1;
      load_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      sframe_q <= SFRAME;
      load_q   <= load_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign DATA      = data_q;
  assign LOAD      = load_q;
  assign ERR       = err_q;
  assign BUSY      = (state_q == ST_SHIFT) || (state_q == ST_LOAD);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nibble_frame_loader.sv
// Drives two loaders (4 and 3 registers, short timeout) from the same serial
// stream and checks every cycle against a frame-level model.
module tb_nibble_frame_loader;
  import nibble_frame_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic sdi;
  logic svalid;
  logic sframe;

  logic [3:0] data4, data3;
  logic [3:0] load4;
  logic [2:0] load3;
  logic       busy4, busy3, err4, err3;
  loader_state_e dbg4, dbg3;

  int n_total = 0;
  int n_pass  = 0;

  logic [3:0] exp_data4 = 4'h0;
  logic [3:0] exp_data3 = 4'h0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_frame_loader #(.NUM_REGS(4), .ADDR_W(2), .TIMEOUT(8), .TMR_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .SDI(sdi), .SVALID(svalid), .SFRAME(sframe),
    .DATA(data4), .LOAD(load4), .BUSY(busy4), .ERR(err4), .dbg_state(dbg4)
  );

  nibble_frame_loader #(.NUM_REGS(3), .ADDR_W(2), .TIMEOUT(8), .TMR_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .SDI(sdi), .SVALID(svalid), .SFRAME(sframe),
    .DATA(data3), .LOAD(load3), .BUSY(busy3), .ERR(err3), .dbg_state(dbg3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick(input string tag, input logic busy_e, input logic [3:0] l4_e,
                      input logic [2:0] l3_e, input logic e4_e, input logic e3_e);
    @(posedge clk);
    #1;
    chk({tag, "/data4"}, 32'(data4), 32'(exp_data4));
    chk({tag, "/data3"}, 32'(data3), 32'(exp_data3));
    chk({tag, "/load4"}, 32'(load4), 32'(l4_e));
    chk({tag, "/load3"}, 32'(load3), 32'(l3_e));
    chk({tag, "/busy4"}, 32'(busy4), 32'(busy_e));
    chk({tag, "/busy3"}, 32'(busy3), 32'(busy_e));
    chk({tag, "/err4"},  32'(err4),  32'(e4_e));
    chk({tag, "/err3"},  32'(err3),  32'(e3_e));
  endtask

  // Frame-level model: address = top two bits, nibble = low four bits;
  // a register bank of n entries accepts addresses 0..n-1.
  function automatic logic [3:0] model_load(input logic [5:0] f, input int n);
    int a;
    a = int'(f[5:4]);
    return (a < n) ? 4'(1 << a) : 4'h0;
  endfunction

  task automatic send_frame(input string tag, input logic [5:0] f, input int nbits,
                            input int gap_max, input int extra);
    logic [5:0] fr;
    logic [3:0] l4;
    logic [3:0] l3;
    int g;
    exp_q.push_back(f);
    sframe = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      g = $urandom_range(0, gap_max);
      repeat (g) begin
        svalid = 1'b0;
        sdi    = 1'($urandom_range(0, 1));
        tick({tag, "/gap"}, 1'b1, 4'h0, 3'h0, 1'b0, 1'b0);
      end
      svalid = 1'b1;
      sdi    = f[5-i];
      if (i == 5) begin
        fr = exp_q.pop_front();
        l4 = model_load(fr, 4);
        l3 = model_load(fr, 3);
        if (l4 != 4'h0) exp_data4 = fr[3:0];
        if (l3 != 4'h0) exp_data3 = fr[3:0];
        tick({tag, "/load"}, 1'b1, l4, l3[2:0], (l4 == 4'h0), (l3 == 4'h0));
      end else begin
        tick({tag, "/bit"}, 1'b1, 4'h0, 3'h0, 1'b0, 1'b0);
      end
    end
    svalid = 1'b0;
    if (nbits < 6) begin
      fr = exp_q.pop_front();
      sframe = 1'b0;
      tick({tag, "/short"}, 1'b0, 4'h0, 3'h0, 1'b1, 1'b1);
    end else begin
      tick({tag, "/post"}, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
      repeat (extra) begin
        svalid = 1'($urandom_range(0, 1));
        sdi    = 1'($urandom_range(0, 1));
        tick({tag, "/over"}, 1'b0, 4'h0, 3'h0, svalid, svalid);
      end
      svalid = 1'b0;
      sframe = 1'b0;
      tick({tag, "/end"}, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [5:0] f;
    int mode;

    // Reset with the frame envelope held high across it.
    rst = 1'b1; sdi = 1'b0; svalid = 1'b0; sframe = 1'b1;
    exp_data4 = 4'h0; exp_data3 = 4'h0;
    tick("reset0", 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
    tick("reset1", 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) begin
      svalid = 1'b1;
      sdi    = 1'($urandom_range(0, 1));
      tick("held_frame", 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
    end
    svalid = 1'b0; sframe = 1'b0;
    tick("idle", 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);

    // SVALID outside a frame is ignored.
    repeat (3) begin
      svalid = 1'($urandom_range(0, 1));
      sdi    = 1'($urandom_range(0, 1));
      tick("noise", 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
    end
    svalid = 1'b0;

    send_frame("addr2_B", 6'b10_1011, 6, 0, 0);
    send_frame("short3", 6'b01_1100, 3, 2, 0);
    send_frame("addr3_5", 6'b11_0101, 6, 1, 0);
    send_frame("overlong", 6'b00_1001, 6, 0, 3);

    // Stall: two bits then eight idle cycles inside the frame.
    sframe = 1'b1;
    svalid = 1'b1; sdi = 1'b1;
    tick("to_b0", 1'b1, 4'h0, 3'h0, 1'b0, 1'b0);
    sdi = 1'b0;
    tick("to_b1", 1'b1, 4'h0, 3'h0, 1'b0, 1'b0);
    svalid = 1'b0;
    repeat (7) tick("to_idle", 1'b1, 4'h0, 3'h0, 1'b0, 1'b0);
    tick("to_expire", 1'b0, 4'h0, 3'h0, 1'b1, 1'b1);
    repeat (3) begin
      svalid = 1'b1; sdi = 1'($urandom_range(0, 1));
      tick("to_late_bit", 1'b0, 4'h0, 3'h0, 1'b1, 1'b1);
    end
    svalid = 1'b0;
    tick("to_quiet", 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
    sframe = 1'b0;
    tick("to_end", 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);

    // Reset in the middle of a frame, envelope still high afterwards.
    sframe = 1'b1; svalid = 1'b1;
    repeat (3) begin
      sdi = 1'($urandom_range(0, 1));
      tick("mid_bits", 1'b1, 4'h0, 3'h0, 1'b0, 1'b0);
    end
    rst = 1'b1; svalid = 1'b0;
    exp_data4 = 4'h0; exp_data3 = 4'h0;
    tick("mid_rst", 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (4) begin
      svalid = 1'b1; sdi = 1'($urandom_range(0, 1));
      tick("mid_ignored", 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
    end
    svalid = 1'b0; sframe = 1'b0;
    tick("mid_low", 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
    send_frame("addr0_3", 6'b00_0011, 6, 0, 0);

    // Randomized frames, gaps shorter than the timeout.
    for (int k = 0; k < 30; k++) begin
      f    = 6'($urandom_range(0, 63));
      mode = $urandom_range(0, 7);
      if (mode == 7) send_frame("rnd_short", f, $urandom_range(1, 5), 3, 0);
      else           send_frame("rnd", f, 6, 5, $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) begin
        svalid = 1'($urandom_range(0, 1));
        sdi    = 1'($urandom_range(0, 1));
        tick("rnd_gap", 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
      end
      svalid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
